// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher and the button/debounce layer:
// FSM state encoding and the 100 MHz millisecond cycle count.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    PS_IDLE = 2'b00,
    PS_ON   = 2'b01,
    PS_GAP  = 2'b10
  } ps_state_e;

  localparam int unsigned CYC_PER_MS = 100_000;

endpackage

// File: rtl/pulse_stretch_if.sv
// Event/level bundle between the debounced-button layer (master) and the
// pulse stretcher (slave).
interface pulse_stretch_if #(
  parameter int PEND_W = 4
);
  import pulse_stretch_pkg::*;

  logic              pulse_in;
  logic              level_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output pulse_in,
    input  level_out,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  pulse_in,
    output level_out,
    output busy,
    output pending,
    output overflow
  );

endinterface

// File: rtl/pulse_stretch_sat_counter.sv
// Saturating up/down counter holding the number of queued events.
// Simultaneous inc and dec cancel; an inc at full scale is dropped and
// flagged for one cycle.
module sat_counter
  import pulse_stretch_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_overflow
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_count;
  logic         r_overflow;

  // Count update with saturation at both ends and registered overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (i_inc && !i_dec) begin
        if (r_count == MAX) r_overflow <= 1'b1;
        else                r_count    <= r_count + W'(1);
      end else if (i_dec && !i_inc && (r_count != '0)) begin
        r_count <= r_count - W'(1);
      end
    end
  end

  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/pulse_stretch.sv
// Pulse stretcher: turns single-cycle events into ON_CYCLES-long high levels
// followed by a GAP_CYCLES low gap. Events arriving while busy are queued
// when PULSE_STRETCH_QUEUE_EN is defined; otherwise they are dropped and
// reported on overflow.
//
// state   | meaning
// --------+--------------------------------------------------------
// PS_IDLE | output low, waiting for an event
// PS_ON   | output high, timer counts to ON_CYCLES-1
// PS_GAP  | forced low gap, timer counts to GAP_CYCLES-1, then replay/idle
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int          CNT_W      = 24,
  parameter int unsigned ON_CYCLES  = 10_000_000,
  parameter int unsigned GAP_CYCLES = 5_000_000,
  parameter int          PEND_W     = 4
) (
  input  logic           clk,
  input  logic           rst,
  pulse_stretch_if.slave bus
);

  if (ON_CYCLES == 0 || longint'(ON_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_on
    $error("ON_CYCLES must be >= 1 and fit in CNT_W bits");
  end
  if (GAP_CYCLES == 0 || longint'(GAP_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_gap
    $error("GAP_CYCLES must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  ps_state_e        r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_level;
  logic             r_busy;

  logic              w_on_done;
  logic              w_gap_done;
  logic              w_has_pend;
  logic              w_restart;
  logic              w_evt_queued;
  logic [PEND_W-1:0] w_pending;
  logic              w_overflow;

  assign w_on_done  = (r_state == PS_ON)  && (r_timer == ON_LAST);
  assign w_gap_done = (r_state == PS_GAP) && (r_timer == GAP_LAST);
  assign w_has_pend = (w_pending != '0);
  assign w_restart  = w_gap_done && (w_has_pend || bus.pulse_in);
  // A pulse on the gap's last cycle with nothing queued is consumed directly.
  assign w_evt_queued = bus.pulse_in && (r_state != PS_IDLE) &&
                        !(w_gap_done && !w_has_pend);

`ifdef PULSE_STRETCH_QUEUE_EN
  sat_counter #(.W(PEND_W)) u_pend (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (w_evt_queued),
    .i_dec      (w_gap_done && w_has_pend),
    .o_count    (w_pending),
    .o_overflow (w_overflow)
  );
`else
  logic r_drop;

  assign w_pending = '0;

  // Without a queue every busy-time event is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) r_drop <= 1'b0;
    else     r_drop <= w_evt_queued;
  end

  assign w_overflow = r_drop;
`endif

  // Phase sequencing; level and busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PS_IDLE;
      r_timer <= '0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        PS_IDLE: begin
          if (bus.pulse_in) begin
            r_state <= PS_ON;
            r_timer <= '0;
            r_level <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        PS_ON: begin
          if (w_on_done) begin
            r_state <= PS_GAP;
            r_timer <= '0;
            r_level <= 1'b0;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        PS_GAP: begin
          if (w_gap_done) begin
            r_timer <= '0;
            if (w_restart) begin
              r_state <= PS_ON;
              r_level <= 1'b1;
            end else begin
              r_state <= PS_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        default: begin
          r_state <= PS_IDLE;
          r_timer <= '0;
          r_level <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.level_out = r_level;
  assign bus.busy      = r_busy;
  assign bus.pending   = w_pending;
  assign bus.overflow  = w_overflow;

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench for pulse_stretch. The reference model keeps a list of
// scheduled output windows (start cycles); each event is placed after the
// last scheduled window and accepted only if the number of windows still
// waiting to start stays within the queue depth.
module tb_pulse_stretch;

  localparam int CNT_W = 8;
  localparam int ON    = 4;
  localparam int GAP   = 2;
  localparam int PW    = 2;
`ifdef PULSE_STRETCH_QUEUE_EN
  localparam int MAXQ = (1 << PW) - 1;
`else
  localparam int MAXQ = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   mon_cyc = 0;

  pulse_stretch_if #(.PEND_W(PW)) bus ();

  pulse_stretch #(
    .CNT_W      (CNT_W),
    .ON_CYCLES  (ON),
    .GAP_CYCLES (GAP),
    .PEND_W     (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          lvl;
    logic          bsy;
    logic [PW-1:0] pend;
    logic          ovf;
  } exp_t;

  exp_t expq[$];
  int   starts[$];
  int   last_end = -100;
  int   cyc = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, mon_cyc, act, want);
    end
  endtask

  // Drive one cycle of inputs and push the expected outputs for the next cycle.
  task automatic step(input logic p, input logic r);
    exp_t e;
    int   s;
    int   cnt;
    int   k;
    @(negedge clk);
    bus.pulse_in = p;
    rst          = r;
    e.ovf = 1'b0;
    if (r) begin
      starts.delete();
      last_end = -100;
    end else if (p) begin
      s   = ((cyc > last_end) ? cyc : last_end) + 1;
      cnt = (s > cyc + 1) ? 1 : 0;
      foreach (starts[i]) if (starts[i] > cyc + 1) cnt++;
      if (cnt <= MAXQ) begin
        starts.push_back(s);
        last_end = s + ON + GAP - 1;
      end else begin
        e.ovf = 1'b1;
      end
    end
    k = cyc + 1;
    while (starts.size() > 0 && starts[0] + ON + GAP - 1 < k) void'(starts.pop_front());
    e.lvl = 1'b0;
    e.bsy = 1'b0;
    cnt   = 0;
    foreach (starts[i]) begin
      if (starts[i] <= k && k <= starts[i] + ON - 1) e.lvl = 1'b1;
      if (starts[i] <= k) e.bsy = 1'b1;
      if (starts[i] > k) cnt++;
    end
    e.pend = PW'(cnt);
    expq.push_back(e);
    cyc++;
  endtask

  task automatic scen(input logic [63:0] pm, input logic [63:0] rm);
    for (int i = 0; i < 64; i++) step(pm[i], rm[i]);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle.
  initial begin
    exp_t m;
    forever begin
      @(posedge clk);
      #2;
      mon_cyc++;
      if (expq.size() > 0) begin
        m = expq.pop_front();
        chk("level_out", 8'(bus.level_out), 8'(m.lvl));
        chk("busy",      8'(bus.busy),      8'(m.bsy));
        chk("pending",   8'(bus.pending),   8'(m.pend));
        chk("overflow",  8'(bus.overflow),  8'(m.ovf));
      end
    end
  end

  initial begin
    #400_000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", mon_cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dens;
    bus.pulse_in = 1'b0;
    rst          = 1'b1;
    repeat (3) step(1'b0, 1'b1);
    scen(64'h400,   64'h0);     // single event
    scen(64'h3400,  64'h0);     // events at 10, 12, 13
    scen(64'h7C00,  64'h0);     // five in a row: saturation
    scen(64'h10400, 64'h0);     // event on last gap cycle
    scen(64'hC00,   64'h1000);  // reset mid-ON with one queued
    scen(64'h13C00, 64'h0);     // full queue plus event at gap exit
    scen(64'h1BC00, 64'h0);     // full queue, drop, then gap-exit event
    dens = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) dens = int'($urandom_range(1, 9));
      step($urandom_range(0, dens) == 0, $urandom_range(0, 299) == 0);
    end
    repeat (40) step(1'b0, 1'b0);
    @(posedge clk);
    #4;
    chk("drain", 8'(expq.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
